// File: rtl/glip_uart_pkg.sv
// Shared definitions for the configurable GLIP UART receiver and transmitter.
//   PARITY_*      parity mode encodings used by the PARITY parameter
//   uart_state_e  receiver frame FSM state encoding
//   majority3     2-of-3 vote used for per-bit oversampling
package glip_uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/glip_uart_receive_cfg_if.sv
// Receiver output bundle: one-entry valid/ready character register plus the
// single-cycle status pulses.
//   out_data/out_valid  character register (master drives)
//   out_ready           consumer accept (slave drives)
//   err_frame, err_parity, err_overrun, break_det  one-cycle pulses
interface glip_uart_receive_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 err_frame;
  logic                 err_parity;
  logic                 err_overrun;
  logic                 break_det;

  modport master (
    output out_data, out_valid, err_frame, err_parity, err_overrun, break_det,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, err_frame, err_parity, err_overrun, break_det,
    output out_ready
  );

endinterface

// File: rtl/glip_uart_bit_sampler.sv
// Line front end for the UART receiver: 2-flop synchroniser, falling-edge
// detect, free-running bit-time counter and 3-sample majority vote.
//   clk, rst      clock, synchronous active-high reset
//   rx            asynchronous serial line (idle high)
//   cnt_clr       restart the bit counter at 0 on the next edge
//   rx_s          synchronised line
//   fall          rx_s went 1 -> 0 on the last edge
//   sample_valid  voted bit available this cycle (count DIVISOR/2+1)
//   sample        2-of-3 majority of counts DIVISOR/2-1, DIVISOR/2, DIVISOR/2+1
//   bit_last      counter is at DIVISOR-1 (bit time ends on this edge)
module glip_uart_bit_sampler
  import glip_uart_pkg::*;
#(
  parameter int unsigned DIVISOR = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic cnt_clr,
  output logic rx_s,
  output logic fall,
  output logic sample_valid,
  output logic sample,
  output logic bit_last
);

  localparam int unsigned CNT_W = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(DIVISOR / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(DIVISOR / 2);
  localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(DIVISOR / 2 + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;
  logic             rx_prev_q, rx_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s0_q, s0_d;
  logic             s1_q, s1_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      rx_prev_q <= rx_prev_d;
      cnt_q     <= cnt_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
    end
  end

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    rx_prev_d = rx_s_q;
    // Explicit wrap so non-power-of-two divisors keep an exact bit time.
    if (cnt_clr || cnt_q == CNT_LAST) cnt_d = '0;
    else                              cnt_d = cnt_q + CNT_W'(1);
    s0_d = (cnt_q == CNT_S0) ? rx_s_q : s0_q;
    s1_d = (cnt_q == CNT_S1) ? rx_s_q : s1_q;
  end

  assign rx_s         = rx_s_q;
  assign fall         = rx_prev_q & ~rx_s_q;
  assign sample_valid = (cnt_q == CNT_S2);
  // Third sample is taken live, so the vote lands in the same cycle.
  assign sample       = majority3(s0_q, s1_q, rx_s_q);
  assign bit_last     = (cnt_q == CNT_LAST);

endmodule

// File: rtl/glip_uart_receive_cfg.sv
// Configurable UART receiver (5..9 data bits, none/odd/even parity, 1 or 2
// stop bits) with break detection and a one-entry valid/ready output register.
//   clk, rst  I/O clock, synchronous active-high reset
//   rx        asynchronous serial line, idle high
//   rx_if     output bundle (master): character register and status pulses
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | line idle, waiting for a falling edge
// ST_START     | checking the start bit; a majority 1 is a glitch
// ST_DATA      | shifting data bits in, LSB first
// ST_PARITY    | capturing the parity bit
// ST_STOP      | sampling stop bit(s); last one triggers the frame decision
// ST_WAIT_IDLE | line still low after the frame, waiting for it to go high
module glip_uart_receive_cfg
  import glip_uart_pkg::*;
#(
  parameter int unsigned DIVISOR   = 16,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  glip_uart_receive_cfg_if.master  rx_if
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] IDX_DATA_END  = IDX_W'(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic PAR_EN  = (PARITY != PARITY_NONE);
  localparam logic PAR_ODD = (PARITY == PARITY_ODD);

  logic rx_s, fall, sample_valid, sample, bit_last;
  logic cnt_clr;

  glip_uart_bit_sampler #(
    .DIVISOR (DIVISOR)
  ) u_sampler (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .cnt_clr      (cnt_clr),
    .rx_s         (rx_s),
    .fall         (fall),
    .sample_valid (sample_valid),
    .sample       (sample),
    .bit_last     (bit_last)
  );

  uart_state_e          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop_bad_q, stop_bad_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;

  logic decide, stop_bad_now, is_break, is_frame, deliver, par_mismatch, overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      shreg_q     <= '0;
      par_bit_q   <= 1'b0;
      stop_bad_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      par_bit_q   <= par_bit_d;
      stop_bad_q  <= stop_bad_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    par_bit_d  = par_bit_q;
    stop_bad_d = stop_bad_q;
    cnt_clr    = 1'b0;
    decide     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          cnt_clr    = 1'b1;
          state_d    = ST_START;
          idx_d      = '0;
          par_bit_d  = 1'b0;
          stop_bad_d = 1'b0;
        end
      end
      ST_START: begin
        if (sample_valid && sample) state_d = ST_IDLE;
        else if (bit_last)          state_d = ST_DATA;
      end
      ST_DATA: begin
        if (sample_valid) begin
          shreg_d = {sample, shreg_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
        end
        // Uses idx_d: with DIVISOR=4 the vote and the bit end share a cycle.
        if (bit_last && idx_d == IDX_DATA_END) begin
          idx_d   = '0;
          state_d = PAR_EN ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (sample_valid) par_bit_d = sample;
        if (bit_last) begin
          idx_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample_valid) begin
          if (idx_q == IDX_STOP_LAST) begin
            decide  = 1'b1;
            state_d = rx_s ? ST_IDLE : ST_WAIT_IDLE;
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            stop_bad_d = stop_bad_q | ~sample;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stop_bad_now = stop_bad_q | ~sample;
  assign is_break     = decide & stop_bad_now & (shreg_q == '0) & ~(PAR_EN & par_bit_q);
  assign is_frame     = decide & stop_bad_now & ~is_break;
  assign deliver      = decide & ~stop_bad_now;
  assign par_mismatch = (^shreg_q) ^ par_bit_q ^ PAR_ODD;
  assign overrun      = deliver & out_valid_q & ~rx_if.out_ready;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (deliver && !overrun) begin
      out_data_d  = shreg_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && rx_if.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pulses are combinational from the decision cycle; masking with rst keeps
  // them quiet while a frame is being aborted.
  assign rx_if.out_data    = out_data_q;
  assign rx_if.out_valid   = out_valid_q;
  assign rx_if.err_frame   = ~rst & is_frame;
  assign rx_if.break_det   = ~rst & is_break;
  assign rx_if.err_parity  = ~rst & deliver & PAR_EN & par_mismatch;
  assign rx_if.err_overrun = ~rst & overrun;

endmodule
